// File: rtl/x_ctrl_pkg.sv
// Shared definitions for the x_ctrl accumulator micro-controller: opcodes, ALU ops,
// default widths and internal register addresses.
package x_ctrl_pkg;

  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefInstrW    = 32;
  localparam int unsigned DefAddrW     = 12;
  localparam int unsigned DefProgAddrW = 10;

  // Width of the immediate field below the 4-bit opcode.
  localparam int unsigned ImmW = 28;

  typedef enum logic [3:0] {
    OpAddi  = 4'h0,
    OpAdd   = 4'h1,
    OpSub   = 4'h2,
    OpShft  = 4'h3,
    OpAnd   = 4'h4,
    OpXor   = 4'h5,
    OpLdi   = 4'h6,
    OpLdih  = 4'h7,
    OpRdw   = 4'h8,
    OpWrw   = 4'h9,
    OpRdwb  = 4'hA,
    OpWrwb  = 4'hB,
    OpBeqi  = 4'hC,
    OpBeq   = 4'hD,
    OpBneqi = 4'hE,
    OpBneq  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluXor  = 3'd3,
    AluShft = 3'd4,
    AluLdih = 3'd5
  } alu_op_e;

  localparam logic [1:0] RegAddrRa = 2'd0;
  localparam logic [1:0] RegAddrRb = 2'd1;
  localparam logic [1:0] RegAddrRc = 2'd2;

  // Ops that read a memory operand and therefore take an E1/E2 pair.
  function automatic logic is_mem_op(input opcode_e op);
    return op inside {OpAdd, OpSub, OpAnd, OpXor, OpRdw, OpRdwb, OpBeq, OpBneq};
  endfunction

  function automatic logic is_wr_op(input opcode_e op);
    return op inside {OpWrw, OpWrwb};
  endfunction

  function automatic logic is_rb_rel(input opcode_e op);
    return op inside {OpRdwb, OpWrwb};
  endfunction

endpackage

// File: rtl/x_ctrl_alu.sv
// Combinational accumulator ALU: combines RA with an operand and produces the
// result plus the carry-out used for RC.
module x_ctrl_alu
  import x_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int unsigned HalfW = DATA_W / 2;

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = a;
    carry  = 1'b0;
    unique case (op)
      AluAdd: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      AluSub: begin
        // a + ~b + 1: carry-out is set when no borrow occurs.
        sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      AluAnd:  result = a & b;
      AluXor:  result = a ^ b;
      AluShft: begin
        if (b[DATA_W-1]) begin
          result = {a[DATA_W-2:0], 1'b0};
        end else begin
          result = {a[DATA_W-1], a[DATA_W-1:1]};
        end
      end
      AluLdih: result = {b[HalfW-1:0], a[HalfW-1:0]};
      default: result = a;
    endcase
  end

endmodule

// File: rtl/x_ctrl.sv
// Accumulator micro-controller: fetch/execute pipeline with one branch delay slot,
// two-cycle memory-operand ops and a single-master data bus.
module x_ctrl
  import x_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned INSTR_W     = DefInstrW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned PROG_ADDR_W = DefProgAddrW
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PROG_ADDR_W-1:0] pc,
  input  logic [INSTR_W-1:0]     instruction,
  output logic                   data_sel,
  output logic                   data_we,
  output logic [ADDR_W-1:0]      data_addr,
  input  logic [DATA_W-1:0]      data_to_rd,
  output logic [DATA_W-1:0]      data_to_wr
);

  localparam logic [1:0] StBubble = 2'd0;
  localparam logic [1:0] StExec   = 2'd1;
  localparam logic [1:0] StMem2   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PROG_ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]      ra_q, ra_d;
  logic [DATA_W-1:0]      rb_q, rb_d;
  logic                   rc_q, rc_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;

  logic [INSTR_W-1:0] cur_instr;
  opcode_e            opcode;
  logic [DATA_W-1:0]  imm;
  logic [ADDR_W-1:0]  op_addr;
  logic               addr_internal;
  logic               active;
  logic               mem_op;
  logic               wr_op;
  logic               in_e1;
  logic               retire;
  logic               ra_zero;
  logic [DATA_W-1:0]  reg_rd;
  logic [DATA_W-1:0]  mem_data;

  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  // In E2 the fetched word belongs to the next instruction, so replay the latched one.
  assign cur_instr = (state_q == StMem2) ? instr_q : instruction;
  assign opcode    = opcode_e'(cur_instr[INSTR_W-1 -: 4]);
  assign imm       = {{(DATA_W - ImmW){cur_instr[ImmW-1]}}, cur_instr[ImmW-1:0]};

  assign mem_op  = is_mem_op(opcode);
  assign wr_op   = is_wr_op(opcode);
  assign active  = (state_q == StExec) || (state_q == StMem2);
  assign in_e1   = (state_q == StExec) && mem_op;
  assign retire  = ((state_q == StExec) && !mem_op) || (state_q == StMem2);
  assign ra_zero = (ra_q == '0);

  always_comb begin
    if (is_rb_rel(opcode)) begin
      op_addr = rb_q[ADDR_W-1:0] + imm[ADDR_W-1:0];
    end else begin
      op_addr = imm[ADDR_W-1:0];
    end
  end

  assign addr_internal = (op_addr[ADDR_W-1:2] == '0);

  always_comb begin
    reg_rd = '0;
    case (op_addr[1:0])
      RegAddrRa: reg_rd = ra_q;
      RegAddrRb: reg_rd = rb_q;
      RegAddrRc: reg_rd = {{(DATA_W - 1){1'b0}}, rc_q};
      default:   reg_rd = '0;
    endcase
  end

  assign mem_data = addr_internal ? reg_rd : data_to_rd;

  // Bus decode; reset gates the strobes so an aborted write never reaches the bus.
  assign pc         = pc_q;
  assign data_sel   = !rst && (state_q == StExec) && (mem_op || wr_op) && !addr_internal;
  assign data_we    = !rst && (state_q == StExec) && wr_op && !addr_internal;
  assign data_addr  = (active && !rst) ? op_addr : '0;
  assign data_to_wr = ra_q;

  always_comb begin
    alu_op = AluAdd;
    alu_b  = mem_data;
    case (opcode)
      OpAddi: alu_b = imm;
      OpSub:  alu_op = AluSub;
      OpAnd:  alu_op = AluAnd;
      OpXor:  alu_op = AluXor;
      OpShft: begin
        alu_op = AluShft;
        alu_b  = imm;
      end
      OpLdih: begin
        alu_op = AluLdih;
        alu_b  = imm;
      end
      default: begin
        alu_op = AluAdd;
        alu_b  = mem_data;
      end
    endcase
  end

  x_ctrl_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op    (alu_op),
    .a     (ra_q),
    .b     (alu_b),
    .result(alu_result),
    .carry (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = in_e1 ? pc_q : pc_q + PROG_ADDR_W'(1);
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    instr_d = in_e1 ? instruction : instr_q;

    case (state_q)
      StBubble: state_d = StExec;
      StExec:   state_d = mem_op ? StMem2 : StExec;
      StMem2:   state_d = StExec;
      default:  state_d = StBubble;
    endcase

    if (retire) begin
      case (opcode)
        OpAddi, OpAdd, OpSub: begin
          ra_d = alu_result;
          rc_d = alu_carry;
        end
        OpShft, OpAnd, OpXor, OpLdih: ra_d = alu_result;
        OpLdi:         ra_d = imm;
        OpRdw, OpRdwb: ra_d = mem_data;
        OpWrw, OpWrwb: begin
          // Writing RA to itself is a no-op; RC is read-only.
          if (addr_internal && (op_addr[1:0] == RegAddrRb)) begin
            rb_d = ra_q;
          end
        end
        OpBeqi:  if (ra_zero) pc_d = imm[PROG_ADDR_W-1:0];
        OpBeq:   if (ra_zero) pc_d = mem_data[PROG_ADDR_W-1:0];
        OpBneqi: if (!ra_zero) pc_d = imm[PROG_ADDR_W-1:0];
        OpBneq:  if (!ra_zero) pc_d = mem_data[PROG_ADDR_W-1:0];
        default: ra_d = ra_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBubble;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_x_ctrl.sv
// Directed bench for x_ctrl: synchronous program/data memory models and
// cycle-exact checks of bus, pc and accumulator behaviour.
module tb_x_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pc;
  logic [31:0] instruction = '0;
  logic        data_sel;
  logic        data_we;
  logic [11:0] data_addr;
  logic [31:0] data_to_rd = '0;
  logic [31:0] data_to_wr;

  logic [31:0] prog [0:1023];
  logic [31:0] dmem [0:4095];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;

  x_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction),
    .data_sel   (data_sel),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_to_rd (data_to_rd),
    .data_to_wr (data_to_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    instruction <= prog[pc];
    if (data_sel && !data_we) data_to_rd <= dmem[data_addr];
    else data_to_rd <= 32'hDEAD_BEEF;
    if (data_sel && data_we) begin
      dmem[data_addr] <= data_to_wr;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) prog[i] = 32'h0000_0000;
    for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
  endtask

  // Leaves the bench #1 after the release edge: the bubble cycle with pc=0.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: LDI 5; ADDI -2; WRW 0x100; RDW 2; WRW 0x101
    clear_mem();
    prog[0] = 32'h6000_0005;
    prog[1] = 32'h0FFF_FFFE;
    prog[2] = 32'h9000_0100;
    prog[3] = 32'h8000_0002;
    prog[4] = 32'h9000_0101;
    do_reset();
    check_eq("rst_pc", {22'b0, pc}, 32'd0);
    check_eq("rst_sel", {31'b0, data_sel}, 32'd0);
    check_eq("rst_we", {31'b0, data_we}, 32'd0);
    check_eq("rst_addr", {20'b0, data_addr}, 32'd0);
    check_eq("rst_ra", data_to_wr, 32'd0);
    tick();
    check_eq("t1_pc1", {22'b0, pc}, 32'd1);
    tick();
    check_eq("t1_ra_ldi", data_to_wr, 32'd5);
    tick();
    check_eq("t1_wr_sel", {31'b0, data_sel}, 32'd1);
    check_eq("t1_wr_we", {31'b0, data_we}, 32'd1);
    check_eq("t1_wr_addr", {20'b0, data_addr}, 32'h100);
    check_eq("t1_wr_data", data_to_wr, 32'd3);
    tick();
    check_eq("t1_int_rd_sel", {31'b0, data_sel}, 32'd0);
    check_eq("t1_e1_pc", {22'b0, pc}, 32'd4);
    tick();
    check_eq("t1_e2_pc", {22'b0, pc}, 32'd4);
    tick();
    check_eq("t1_rc_addr", {20'b0, data_addr}, 32'h101);
    check_eq("t1_rc", data_to_wr, 32'd1);
    check_eq("t1_pc_after", {22'b0, pc}, 32'd5);
    tick();
    check_eq("t1_wr_cnt", wr_cnt, 32'd2);

    // Test 2: M[0x104]=7; RDW 0x104; SUB 0x104; WRW 0x300; RDW 2; WRW 0x301
    clear_mem();
    dmem[12'h104] = 32'd7;
    prog[0] = 32'h8000_0104;
    prog[1] = 32'h2000_0104;
    prog[2] = 32'h9000_0300;
    prog[3] = 32'h8000_0002;
    prog[4] = 32'h9000_0301;
    do_reset();
    tick();
    check_eq("t2_rdw_e1_sel", {31'b0, data_sel}, 32'd1);
    check_eq("t2_rdw_e1_we", {31'b0, data_we}, 32'd0);
    check_eq("t2_rdw_e1_addr", {20'b0, data_addr}, 32'h104);
    check_eq("t2_rdw_e1_pc", {22'b0, pc}, 32'd1);
    tick();
    check_eq("t2_rdw_e2_sel", {31'b0, data_sel}, 32'd0);
    check_eq("t2_rdw_e2_addr", {20'b0, data_addr}, 32'h104);
    check_eq("t2_rdw_e2_pc", {22'b0, pc}, 32'd1);
    tick();
    check_eq("t2_ra_rdw", data_to_wr, 32'd7);
    check_eq("t2_sub_e1_sel", {31'b0, data_sel}, 32'd1);
    check_eq("t2_sub_e1_pc", {22'b0, pc}, 32'd2);
    tick();
    check_eq("t2_sub_e2_sel", {31'b0, data_sel}, 32'd0);
    check_eq("t2_sub_e2_pc", {22'b0, pc}, 32'd2);
    tick();
    check_eq("t2_ra_sub", data_to_wr, 32'd0);
    check_eq("t2_wr_addr", {20'b0, data_addr}, 32'h300);
    tick();
    tick();
    tick();
    check_eq("t2_rc", data_to_wr, 32'd1);
    check_eq("t2_rc_sel", {31'b0, data_sel}, 32'd1);

    // Test 3: LDI 0x10; WRW 1; LDI 9; WRWB 0x200
    clear_mem();
    prog[0] = 32'h6000_0010;
    prog[1] = 32'h9000_0001;
    prog[2] = 32'h6000_0009;
    prog[3] = 32'hB000_0200;
    do_reset();
    tick();
    tick();
    check_eq("t3_wrw1_sel", {31'b0, data_sel}, 32'd0);
    tick();
    tick();
    check_eq("t3_wrwb_sel", {31'b0, data_sel}, 32'd1);
    check_eq("t3_wrwb_we", {31'b0, data_we}, 32'd1);
    check_eq("t3_wrwb_addr", {20'b0, data_addr}, 32'h210);
    check_eq("t3_wrwb_data", data_to_wr, 32'd9);

    // Test 4: LDI 0; BEQI 20; ADDI 1 (delay slot); ADDI 1; @20 WRW 0x400
    clear_mem();
    prog[0]  = 32'h6000_0000;
    prog[1]  = 32'hC000_0014;
    prog[2]  = 32'h0000_0001;
    prog[3]  = 32'h0000_0001;
    prog[20] = 32'h9000_0400;
    do_reset();
    tick();
    tick();
    tick();
    check_eq("t4_target_pc", {22'b0, pc}, 32'd20);
    tick();
    check_eq("t4_ra", data_to_wr, 32'd1);
    check_eq("t4_tgt_addr", {20'b0, data_addr}, 32'h400);
    check_eq("t4_pc_next", {22'b0, pc}, 32'd21);

    // Test 5: LDI 0x1234; LDIH 0xABCD; SHFT -1; SHFT 1
    clear_mem();
    prog[0] = 32'h6000_1234;
    prog[1] = 32'h7000_ABCD;
    prog[2] = 32'h3FFF_FFFF;
    prog[3] = 32'h3000_0001;
    do_reset();
    tick();
    tick();
    check_eq("t5_ldi", data_to_wr, 32'h0000_1234);
    tick();
    check_eq("t5_ldih", data_to_wr, 32'hABCD_1234);
    tick();
    check_eq("t5_shl", data_to_wr, 32'h579A_2468);
    tick();
    check_eq("t5_sar", data_to_wr, 32'h2BCD_1234);

    // Test 6: M[0x108]=30; LDI 1; BNEQ 0x108; ADDI 4 (delay slot); ADDI 100; @30 WRW 0x500
    clear_mem();
    dmem[12'h108] = 32'd30;
    prog[0]  = 32'h6000_0001;
    prog[1]  = 32'hF000_0108;
    prog[2]  = 32'h0000_0004;
    prog[3]  = 32'h0000_0064;
    prog[30] = 32'h9000_0500;
    do_reset();
    tick();
    tick();
    check_eq("t6_bneq_e1_addr", {20'b0, data_addr}, 32'h108);
    tick();
    check_eq("t6_bneq_e2_pc", {22'b0, pc}, 32'd2);
    tick();
    check_eq("t6_target_pc", {22'b0, pc}, 32'd30);
    tick();
    check_eq("t6_ra", data_to_wr, 32'd5);
    check_eq("t6_wr_addr", {20'b0, data_addr}, 32'h500);

    // Test 7: reset asserted during E1 of RDW
    clear_mem();
    prog[0] = 32'h6000_0005;
    prog[1] = 32'h8000_0104;
    do_reset();
    tick();
    tick();
    check_eq("t7_pre_sel", {31'b0, data_sel}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t7_rst_gate_sel", {31'b0, data_sel}, 32'd0);
    tick();
    rst = 1'b0;
    check_eq("t7_pc", {22'b0, pc}, 32'd0);
    check_eq("t7_sel", {31'b0, data_sel}, 32'd0);
    check_eq("t7_ra", data_to_wr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
